fetch_queue: RTL and testbench

- Instruction-fetch front end of the RISC-V pipeline. Sits directly upstream of the instruction decoder (ControlUnit).
- Generates sequential PCs and issues requests to instruction memory, which may have variable latency.
- Buffers returned instructions in a small FIFO and presents the head as the IF/ID register: full instruction, PC, and the Op/Fn3/Fn7 slices the decoder consumes.
- Handles decode-stage stalls and branch/jump redirects, including discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: data widths, decoder field positions and
// small helpers used by the fetch front end and its consumers.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   // Instruction field positions consumed by the decoder
   localparam int OP_LSB  = 0;
   localparam int OP_MSB  = 6;
   localparam int FN3_LSB = 12;
   localparam int FN3_MSB = 14;
   localparam int FN7_LSB = 25;
   localparam int FN7_MSB = 31;

   // addi x0, x0, 0 -- inserted by downstream stages as a bubble
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch result; pc sits in the upper half
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Clear the byte offset so every fetch address is word aligned
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head entry is read straight from
// the storage flops so a consumer sees it in the same cycle it becomes valid.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign rdata = mem_reg[rd_ptr_reg];

   // A flush wins over everything; a push into a full FIFO is allowed
   // only when the head leaves in the same cycle.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   // Storage: cleared on reset so the head reads as zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (do_push) begin
         mem_reg[wr_ptr_reg] <= wdata;
      end
   end

   // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches under a
// credit limit, buffers responses and presents the head as the IF/ID
// register. Redirects flush the buffer and drop every in-flight response.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [ILEN-1:0]   imem_rdata,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              stall_d,
   output logic              instr_valid_d,
   output logic [ILEN-1:0]   instr_d,
   output logic [XLEN-1:0]   pc_d,
   output logic [6:0]        op_d,
   output logic [2:0]        fn3_d,
   output logic [6:0]        fn7_d
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_next;
   logic [CW-1:0]   discard_reg;
   logic [CW-1:0]   discard_next;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   buf_count;
   logic [CW:0]     in_flight;
   logic            issue;
   logic            push_buf;
   logic            pop_buf;
   logic            buf_full;
   logic            buf_empty;
   logic            pcq_full;
   logic            pcq_empty;
   logic [XLEN-1:0] resp_pc;
   fetch_entry_t    entry_in;
   fetch_entry_t    head;

   // Requests in flight plus buffered results may never exceed DEPTH, which
   // guarantees every response has a FIFO slot. Held off during reset and in
   // a redirect cycle so the stale pc is never fetched.
   assign in_flight = {1'b0, outstanding} + {1'b0, buf_count};
   assign imem_req  = rst_n && !redirect && (in_flight < (CW+1)'(DEPTH));
   assign imem_addr = pc_reg;
   assign issue     = imem_req && imem_gnt;

   // Responses owed to a pre-redirect stream are dropped, as is anything
   // landing in the redirect cycle itself.
   assign push_buf = imem_rvalid && (discard_reg == '0) && !redirect;
   assign pop_buf  = !buf_empty && !stall_d && !redirect;
   assign entry_in = {resp_pc, imem_rdata};

   // Addresses of granted requests, consumed in order as responses return;
   // its occupancy is the outstanding-request count.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (imem_rvalid),
      .flush (1'b0),
      .wdata (pc_reg),
      .rdata (resp_pc),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (outstanding)
   );

   // Returned instructions paired with their pc; the head is the IF/ID register
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_instr_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_buf),
      .pop   (pop_buf),
      .flush (redirect),
      .wdata (entry_in),
      .rdata (head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   assign instr_valid_d = !buf_empty;
   assign instr_d       = head.instr;
   assign pc_d          = head.pc;
   assign op_d          = head.instr[OP_MSB:OP_LSB];
   assign fn3_d         = head.instr[FN3_MSB:FN3_LSB];
   assign fn7_d         = head.instr[FN7_MSB:FN7_LSB];

   // Next fetch pc: a redirect target beats sequential advance; wraps silently
   always_comb begin
      pc_next = pc_reg;
      if (redirect) begin
         pc_next = word_align(redirect_pc);
      end else if (issue) begin
         pc_next = pc_reg + 32'd4;
      end
   end

   // Discard count: a redirect marks every request still live after this
   // cycle as stale; each response then retires one stale entry.
   always_comb begin
      discard_next = discard_reg;
      if (redirect) begin
         discard_next = outstanding - CW'(imem_rvalid);
      end else if (imem_rvalid && (discard_reg != '0)) begin
         discard_next = discard_reg - 1'b1;
      end
   end

   // Fetch pc and discard state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg      <= word_align(RESET_PC);
         discard_reg <= '0;
      end else begin
         pc_reg      <= pc_next;
         discard_reg <= discard_next;
      end
   end

   // Interface and bookkeeping invariants checked while out of reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rvalid && pcq_empty));
         assert (discard_reg <= outstanding);
         assert (!(issue && pcq_full));
         assert (!(push_buf && buf_full && !pop_buf));
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a variable-latency in-order memory model plus a
// stream-level reference (expected fetch address, expected ID pc, counts of
// pending and buffered instructions) checked every cycle.
module tb_fetch_queue;
   import riscv_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall_d = 1'b0;
   logic        instr_valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [6:0]  op_d;
   logic [2:0]  fn3_d;
   logic [6:0]  fn7_d;

   always #5 clk = ~clk;

   fetch_queue #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .stall_d       (stall_d),
      .instr_valid_d (instr_valid_d),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .op_d          (op_d),
      .fn3_d         (fn3_d),
      .fn7_d         (fn7_d)
   );

   typedef struct {
      logic [31:0] addr;
      int          ready;
      bit          stale;
   } mem_t;

   mem_t        mem_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_ready = 0;
   int          buffered = 0;
   int          consumed = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          gnt_rand = 1'b0;
   logic [31:0] req_pc;
   logic [31:0] exp_pc;
   logic        s_valid;
   logic        s_req;
   logic [31:0] s_pc;
   logic [31:0] s_addr;
   logic [6:0]  s_op;
   logic [2:0]  s_fn3;
   logic [6:0]  s_fn7;

   // Memory contents: distinct word per address; address 0 holds 32'h40B5_0533
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h40B5_0533;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_bound(input string tag, input int n, input int limit);
      vectors++;
      assert (n < limit) else begin
         miscompares++;
         $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, limit);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic step(input bit redir, input logic [31:0] tgt, input bit stl);
      bit          rv;
      bit          gnt;
      bit          exp_req;
      bit          exp_valid;
      bit          push;
      bit          pop;
      logic [31:0] e;
      mem_t        m;
      int          rdy;
      gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      rv  = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
      redirect    = redir;
      redirect_pc = tgt;
      stall_d     = stl;
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_q[0].addr) : $urandom;
      #1;
      exp_req   = !redir && ((mem_q.size() + buffered) < DEPTH);
      exp_valid = (buffered > 0);
      s_valid = instr_valid_d;
      s_req   = imem_req;
      s_pc    = pc_d;
      s_addr  = imem_addr;
      s_op    = op_d;
      s_fn3   = fn3_d;
      s_fn7   = fn7_d;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, req_pc);
      chk("instr_valid_d", 32'(instr_valid_d), 32'(exp_valid));
      if (exp_valid) begin
         e = mem_word(exp_pc);
         chk("pc_d", pc_d, exp_pc);
         chk("instr_d", instr_d, e);
         chk("op_d", 32'(op_d), 32'(e[6:0]));
         chk("fn3_d", 32'(fn3_d), 32'(e[14:12]));
         chk("fn7_d", 32'(fn7_d), 32'(e[31:25]));
      end
      @(posedge clk);
      push = 1'b0;
      if (rv) begin
         m = mem_q.pop_front();
         push = !m.stale && !redir;
      end
      pop = exp_valid && !stl && !redir;
      if (pop) begin
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      if (redir) begin
         buffered = 0;
         for (int i = 0; i < mem_q.size(); i++) begin
            m = mem_q[i];
            m.stale = 1'b1;
            mem_q[i] = m;
         end
         exp_pc = {tgt[31:2], 2'b00};
         req_pc = exp_pc;
      end else begin
         buffered = buffered + int'(push) - int'(pop);
      end
      if (exp_req && gnt) begin
         rdy = cyc + $urandom_range(lat_max, lat_min);
         if (rdy <= last_ready) rdy = last_ready + 1;
         m.addr  = req_pc;
         m.ready = rdy;
         m.stale = 1'b0;
         mem_q.push_back(m);
         last_ready = rdy;
         req_pc = req_pc + 32'd4;
      end
      cyc++;
      @(negedge clk);
   endtask

   // Assert reset for one clock (memory resets with it) and check reset outputs
   task automatic do_reset();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      stall_d     = 1'b0;
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_instr_valid_d", 32'(instr_valid_d), 32'd0);
      chk("rst_instr_d", instr_d, 32'd0);
      chk("rst_pc_d", pc_d, 32'd0);
      chk("rst_op_d", 32'(op_d), 32'd0);
      chk("rst_fn3_d", 32'(fn3_d), 32'd0);
      chk("rst_fn7_d", 32'(fn7_d), 32'd0);
      mem_q.delete();
      buffered = 0;
      req_pc   = RESET_PC;
      exp_pc   = RESET_PC;
      @(posedge clk);
      cyc++;
      last_ready = cyc;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          n;
      bit          stl;
      bit          rd;
      logic [31:0] tgt;
      req_pc = RESET_PC;
      exp_pc = RESET_PC;
      @(negedge clk);
      do_reset();

      // Reset release, 1-cycle memory, always granted
      step(1'b0, '0, 1'b0);
      chk("first_req", 32'(s_req), 32'd1);
      chk("first_addr", s_addr, RESET_PC);
      step(1'b0, '0, 1'b0);
      chk("valid_not_yet", 32'(s_valid), 32'd0);
      step(1'b0, '0, 1'b0);
      chk("valid_after_2", 32'(s_valid), 32'd1);
      chk("first_pc", s_pc, RESET_PC);
      chk("op_slice", 32'(s_op), 32'h33);
      chk("fn3_slice", 32'(s_fn3), 32'h0);
      chk("fn7_slice", 32'(s_fn7), 32'h20);
      repeat (10) step(1'b0, '0, 1'b0);

      // Decode stall for 5 cycles: credits run out, stream resumes intact
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      chk("stall_req_dropped", 32'(s_req), 32'd0);
      repeat (8) step(1'b0, '0, 1'b0);

      // Redirect with two requests outstanding on a 3-cycle memory
      lat_min = 3;
      lat_max = 3;
      n = 0;
      while (mem_q.size() != 2 && n < 50) begin
         step(1'b0, '0, 1'b0);
         n++;
      end
      chk_bound("wait_two_outstanding", n, 50);
      step(1'b1, 32'h0000_0100, 1'b0);
      n = 0;
      do begin
         step(1'b0, '0, 1'b0);
         n++;
      end while (!s_valid && n < 30);
      chk_bound("wait_redirect_valid", n, 30);
      chk("redirect_target_pc", s_pc, 32'h0000_0100);

      // Redirect plus stall with a response landing in the same cycle
      lat_min = 1;
      lat_max = 1;
      n = 0;
      while (!(buffered > 0 && mem_q.size() > 0 && mem_q[0].ready <= cyc) && n < 30) begin
         step(1'b0, '0, 1'b1);
         n++;
      end
      chk_bound("wait_rvalid_with_buffered", n, 30);
      step(1'b1, 32'h0000_0202, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("flushed_after_redirect", 32'(s_valid), 32'd0);
      n = 0;
      while (!s_valid && n < 30) begin
         step(1'b0, '0, 1'b0);
         n++;
      end
      chk_bound("wait_resume_valid", n, 30);
      chk("resume_target_pc", s_pc, 32'h0000_0200);

      // Randomized grant, latency 1..4, stalls and redirects (some near wrap)
      gnt_rand = 1'b1;
      lat_min  = 1;
      lat_max  = 4;
      consumed = 0;
      n = 0;
      while (consumed < 1000 && n < 20000) begin
         stl = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 31) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step(rd, tgt, stl);
         n++;
      end
      chk_bound("random_stream", n, 20000);

      // Reset mid-stream with two requests outstanding
      gnt_rand = 1'b0;
      lat_min  = 3;
      lat_max  = 3;
      n = 0;
      while (mem_q.size() != 2 && n < 50) begin
         step(1'b0, '0, 1'b0);
         n++;
      end
      chk_bound("wait_two_outstanding_rst", n, 50);
      do_reset();
      step(1'b0, '0, 1'b0);
      chk("post_reset_req", 32'(s_req), 32'd1);
      chk("post_reset_addr", s_addr, RESET_PC);
      repeat (12) step(1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
